// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: constants shared by the SD SPI-mode card responder and the
// host-side init sequencer.
//   - command indices (CMD0/8/17/41/55/58)
//   - R1 status bit positions
//   - frame and response widths (48 / 8 / 40)
//   - start and transmission bit values
//   - responder FSM state type and CRC7 single-bit step helper
package sd_spi_pkg;

  localparam int FRAME_W = 48;
  localparam int R1_W    = 8;
  localparam int R37_W   = 40;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE      = 0;
  localparam int R1_ERASE_RST = 1;
  localparam int R1_ILLEGAL   = 2;
  localparam int R1_CRC       = 3;
  localparam int R1_ERASE_SEQ = 4;
  localparam int R1_ADDR      = 5;
  localparam int R1_PARAM     = 6;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_RX,
    ST_NCR,
    ST_RESP
  } resp_state_t;

  // CRC7, polynomial x^7 + x^3 + 1, one message bit per call.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

endpackage

// File: rtl/sd_spi_responder_if.sv
// sd_spi_responder_if: SPI pins plus command-status outputs of the SD card
// responder.
//   master : host side, drives SCK_SPI / spi_cs_n_i / spi_mosi_i
//   slave  : card side, drives MISO and the command/status outputs
interface sd_spi_responder_if;
  logic        SCK_SPI;
  logic        spi_cs_n_i;
  logic        spi_mosi_i;
  logic        spi_miso_o;
  logic        spi_cmdvalid_o;
  logic [5:0]  spi_cmdidx_o;
  logic [31:0] spi_cmdarg_o;
  logic        spi_cardidle_o;
  logic        spi_busy_o;

  modport master (
    output SCK_SPI, spi_cs_n_i, spi_mosi_i,
    input  spi_miso_o, spi_cmdvalid_o, spi_cmdidx_o, spi_cmdarg_o,
           spi_cardidle_o, spi_busy_o
  );

  modport slave (
    input  SCK_SPI, spi_cs_n_i, spi_mosi_i,
    output spi_miso_o, spi_cmdvalid_o, spi_cmdidx_o, spi_cmdarg_o,
           spi_cardidle_o, spi_busy_o
  );
endinterface

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 accumulator over received command bits.
//   clk_i/rst_i : system clock, async active-high reset
//   clr_i       : zero the accumulator (frame start)
//   en_i        : fold din_i into the CRC this cycle
//   crc_o       : running CRC7
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      crc_o <= 7'h00;
    else if (clr_i) crc_o <= 7'h00;
    else if (en_i)  crc_o <= crc7_step(crc_o, din_i);
  end
endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card responder. Deframes 48-bit commands
// from MOSI, tracks idle/ready card state and returns R1/R3/R7 responses.
// Ports:
//   spi_clk_i, spi_rst_i : system clock (>=4x SCK), async active-high reset
//   spi (slave modport)  : SCK_SPI, spi_cs_n_i, spi_mosi_i in;
//                          spi_miso_o, spi_cmdvalid_o, spi_cmdidx_o,
//                          spi_cmdarg_o, spi_cardidle_o, spi_busy_o out
// Build option: define SD_RESP_CRC_CHECK_EN to check CRC7 on CMD0/CMD8.
//
// state   | meaning
// HUNT    | waiting for a start bit (MOSI=0 on an SCK rise)
// RX      | shifting in the remaining 47 frame bits
// NCR     | driving 0xFF gap bytes before the response
// RESP    | shifting the 8- or 40-bit response out on SCK falls
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int          NCR_BYTES       = 1,
  parameter int          ACMD41_BUSY_CNT = 2,
  parameter logic [31:0] OCR_BASE        = 32'h40FF8000
) (
  input logic               spi_clk_i,
  input logic               spi_rst_i,
  sd_spi_responder_if.slave spi
);
  localparam logic [5:0] NCR_LAST = 6'(NCR_BYTES * 8 - 1);

  // 3-stage SCK chain: two sync flops plus one for edge detect.
  logic [2:0] sck_sync;
  logic [1:0] cs_sync, mosi_sync;
  logic       sck_rise, sck_fall, cs_n, mosi;

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      sck_sync  <= 3'b000;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi.SCK_SPI};
      cs_sync   <= {cs_sync[0], spi.spi_cs_n_i};
      mosi_sync <= {mosi_sync[0], spi.spi_mosi_i};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign cs_n     = cs_sync[1];
  assign mosi     = mosi_sync[1];

  resp_state_t state;
  logic [5:0]  bit_cnt, resp_cnt, resp_last;
  logic [46:0] frame;
  logic [39:0] resp_sr;
  logic        app_cmd, cardidle, miso, cmdvalid, busy;
  logic [3:0]  busy_cnt;
  logic [5:0]  cmdidx;
  logic [31:0] cmdarg;

  logic [47:0] frame_nxt;
  logic        frame_ok, crc_ok;
  logic [5:0]  rx_idx;
  logic [31:0] rx_arg;

  assign frame_nxt = {frame, mosi};
  assign frame_ok  = (frame_nxt[47] == START_BIT) && (frame_nxt[46] == TX_BIT) && frame_nxt[0];
  assign rx_idx    = frame_nxt[45:40];
  assign rx_arg    = frame_nxt[39:8];

`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] crc_val;
  logic       crc_clr, crc_en;

  // The start bit is 0, so clearing on it equals folding it in.
  assign crc_clr = (state == ST_HUNT) && sck_rise && !mosi;
  assign crc_en  = (state == ST_RX) && sck_rise && (bit_cnt < 6'd40);

  sd_crc7 u_crc7 (
    .clk_i (spi_clk_i),
    .rst_i (spi_rst_i),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .din_i (mosi),
    .crc_o (crc_val)
  );

  assign crc_ok = !((rx_idx == CMD0) || (rx_idx == CMD8)) || (crc_val == frame_nxt[7:1]);
`else
  logic crc_field_unused;
  assign crc_field_unused = ^frame_nxt[7:1];
  assign crc_ok = 1'b1;
`endif

  logic [7:0]  r1;
  logic [31:0] tail;
  logic        long_resp, idle_nx, app_nx;
  logic [3:0]  cnt_nx;

  always_comb begin
    r1        = {7'b0, cardidle};
    tail      = 32'h0;
    long_resp = 1'b0;
    idle_nx   = cardidle;
    app_nx    = 1'b0;
    cnt_nx    = busy_cnt;
    if (!crc_ok) begin
      r1[R1_CRC] = 1'b1;
    end else begin
      case (rx_idx)
        CMD0: begin
          idle_nx = 1'b1;
          cnt_nx  = 4'(ACMD41_BUSY_CNT);
          r1      = 8'h01;
        end
        CMD8: begin
          long_resp = 1'b1;
          tail      = {20'h0, rx_arg[11:0]};
        end
        CMD55: app_nx = 1'b1;
        CMD41: begin
          if (!app_cmd) begin
            r1[R1_ILLEGAL] = 1'b1;
          end else if (busy_cnt != 4'd0) begin
            cnt_nx = busy_cnt - 4'd1;
            r1     = 8'h01;
          end else begin
            idle_nx = 1'b0;
            r1      = 8'h00;
          end
        end
        CMD58: begin
          long_resp = 1'b1;
          tail      = {~cardidle, OCR_BASE[30:0]};
        end
        default: r1[R1_ILLEGAL] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      state     <= ST_HUNT;
      bit_cnt   <= 6'd0;
      resp_cnt  <= 6'd0;
      resp_last <= 6'd0;
      frame     <= '0;
      resp_sr   <= '1;
      app_cmd   <= 1'b0;
      cardidle  <= 1'b1;
      busy_cnt  <= 4'(ACMD41_BUSY_CNT);
      miso      <= 1'b1;
      cmdvalid  <= 1'b0;
      busy      <= 1'b0;
      cmdidx    <= 6'd0;
      cmdarg    <= 32'h0;
    end else begin
      cmdvalid <= 1'b0;
      if (cs_n) begin
        state <= ST_HUNT;
        miso  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_HUNT: begin
            if (sck_fall) miso <= 1'b1;
            if (sck_rise && !mosi) begin
              state   <= ST_RX;
              bit_cnt <= 6'd1;
              frame   <= '0;
            end
          end
          ST_RX: begin
            if (sck_fall) miso <= 1'b1;
            if (sck_rise) begin
              frame   <= frame_nxt[46:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'(FRAME_W - 1)) begin
                if (frame_ok) begin
                  state     <= ST_NCR;
                  bit_cnt   <= 6'd0;
                  cmdvalid  <= 1'b1;
                  busy      <= 1'b1;
                  cmdidx    <= rx_idx;
                  cmdarg    <= rx_arg;
                  cardidle  <= idle_nx;
                  app_cmd   <= app_nx;
                  busy_cnt  <= cnt_nx;
                  resp_sr   <= {r1, tail};
                  resp_last <= long_resp ? 6'(R37_W - 1) : 6'(R1_W - 1);
                end else begin
                  state <= ST_HUNT;
                end
              end
            end
          end
          ST_NCR: begin
            if (sck_fall) begin
              miso <= 1'b1;
              if (bit_cnt == NCR_LAST) begin
                state    <= ST_RESP;
                resp_cnt <= 6'd0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          ST_RESP: begin
            if (sck_fall) begin
              miso     <= resp_sr[39];
              resp_sr  <= {resp_sr[38:0], 1'b1};
              resp_cnt <= resp_cnt + 6'd1;
              // Last bit stays on MISO until the next fall, seen in HUNT.
              if (resp_cnt == resp_last) begin
                state <= ST_HUNT;
                busy  <= 1'b0;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign spi.spi_miso_o     = miso;
  assign spi.spi_cmdvalid_o = cmdvalid;
  assign spi.spi_cmdidx_o   = cmdidx;
  assign spi.spi_cmdarg_o   = cmdarg;
  assign spi.spi_cardidle_o = cardidle;
  assign spi.spi_busy_o     = busy;
endmodule

// File: tb/tb_sd_spi_responder.sv
module tb_sd_spi_responder;
  localparam int          NCR_BYTES       = 1;
  localparam int          ACMD41_BUSY_CNT = 2;
  localparam logic [31:0] OCR_BASE        = 32'h40FF8000;
  localparam int          HALF            = 60;

  logic spi_clk_i = 1'b0;
  logic spi_rst_i = 1'b1;

  sd_spi_responder_if bus ();

  sd_spi_responder #(
    .NCR_BYTES       (NCR_BYTES),
    .ACMD41_BUSY_CNT (ACMD41_BUSY_CNT),
    .OCR_BASE        (OCR_BASE)
  ) dut (
    .spi_clk_i (spi_clk_i),
    .spi_rst_i (spi_rst_i),
    .spi       (bus)
  );

  always #5 spi_clk_i = ~spi_clk_i;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  always @(negedge spi_clk_i) if (bus.spi_cmdvalid_o === 1'b1) vcount++;

  // card model
  bit          m_idle = 1'b1;
  bit          m_app  = 1'b0;
  int          m_cnt  = ACMD41_BUSY_CNT;
  logic [5:0]  m_idx  = 6'd0;
  logic [31:0] m_arg  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7_of(input logic [39:0] d);
    logic [6:0] c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
      else             c = {c[5:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_of(h), 1'b1};
  endfunction

  task automatic model_cmd(input logic [47:0] f, output bit acc, output int rlen, output logic [39:0] rv);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  st;
    bit          bad_crc;
    acc  = (f[47] == 1'b0) && (f[46] == 1'b1) && (f[0] == 1'b1);
    rlen = 8;
    rv   = 40'hFF;
    if (!acc) return;
    idx = f[45:40];
    arg = f[39:8];
    m_idx = idx;
    m_arg = arg;
    bad_crc = 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
    if ((idx == 6'd0 || idx == 6'd8) && crc7_of(f[47:8]) != f[7:1]) bad_crc = 1'b1;
`endif
    st = m_idle ? 8'h01 : 8'h00;
    if (bad_crc) begin
      rv = 40'(st | 8'h08);
      m_app = 1'b0;
    end else if (idx == 6'd0) begin
      m_idle = 1'b1; m_cnt = ACMD41_BUSY_CNT; m_app = 1'b0;
      rv = 40'h01;
    end else if (idx == 6'd8) begin
      rlen = 40; rv = {st, 20'h0, arg[11:0]}; m_app = 1'b0;
    end else if (idx == 6'd55) begin
      m_app = 1'b1; rv = 40'(st);
    end else if (idx == 6'd41 && m_app) begin
      if (m_cnt > 0) begin m_cnt--; rv = 40'h01; end
      else begin m_idle = 1'b0; rv = 40'h00; end
      m_app = 1'b0;
    end else if (idx == 6'd58) begin
      rlen = 40; rv = {st, !m_idle, OCR_BASE[30:0]}; m_app = 1'b0;
    end else begin
      rv = 40'(st | 8'h04); m_app = 1'b0;
    end
  endtask

  task automatic do_cmd(input string name, input logic [47:0] f, input bit has_lit, input logic [39:0] lit);
    bit          acc, miso_hi, ncr_ok;
    int          rlen, v0;
    logic [39:0] exp, got;
    logic        busy_seen;
    model_cmd(f, acc, rlen, exp);
    v0 = vcount; miso_hi = 1'b1; ncr_ok = 1'b1; got = '0; busy_seen = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      bus.spi_mosi_i = f[i];
      #HALF bus.SCK_SPI = 1'b1;
      if (bus.spi_miso_o !== 1'b1) miso_hi = 1'b0;
      #HALF;
      if (i == 0) busy_seen = bus.spi_busy_o;
      bus.SCK_SPI = 1'b0;
    end
    bus.spi_mosi_i = 1'b1;
    for (int k = 1; k <= NCR_BYTES * 8 + rlen; k++) begin
      #HALF bus.SCK_SPI = 1'b1;
      if (k <= NCR_BYTES * 8) begin
        if (bus.spi_miso_o !== 1'b1) ncr_ok = 1'b0;
      end else begin
        got = {got[38:0], bus.spi_miso_o};
      end
      #HALF bus.SCK_SPI = 1'b0;
    end
    #HALF;
    check({name, " miso_idle"}, miso_hi, 1'b1);
    check({name, " ncr_ff"}, ncr_ok, 1'b1);
    check({name, " resp"}, got, exp);
    if (has_lit) check({name, " resp_lit"}, got, lit);
    check({name, " cmdvalid_cycles"}, vcount - v0, acc ? 1 : 0);
    check({name, " busy_during"}, busy_seen, acc);
    check({name, " busy_after"}, bus.spi_busy_o, 1'b0);
    check({name, " cardidle"}, bus.spi_cardidle_o, m_idle);
    if (acc) begin
      check({name, " cmdidx"}, bus.spi_cmdidx_o, m_idx);
      check({name, " cmdarg"}, bus.spi_cmdarg_o, m_arg);
    end
  endtask

  task automatic abort_after(input logic [47:0] f, input int nbits);
    int v0;
    v0 = vcount;
    for (int i = 47; i > 47 - nbits; i--) begin
      bus.spi_mosi_i = f[i];
      #HALF bus.SCK_SPI = 1'b1;
      #HALF bus.SCK_SPI = 1'b0;
    end
    bus.spi_mosi_i = 1'b1;
    bus.spi_cs_n_i = 1'b1;
    repeat (4) #HALF;
    check("abort busy", bus.spi_busy_o, 1'b0);
    check("abort miso", bus.spi_miso_o, 1'b1);
    check("abort cmdvalid", vcount - v0, 0);
    check("abort cardidle", bus.spi_cardidle_o, m_idle);
    bus.spi_cs_n_i = 1'b0;
    repeat (2) #HALF;
  endtask

  initial begin
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] f;
    int          sel;
    bus.SCK_SPI    = 1'b0;
    bus.spi_cs_n_i = 1'b1;
    bus.spi_mosi_i = 1'b1;
    repeat (3) @(negedge spi_clk_i);
    check("rst miso", bus.spi_miso_o, 1'b1);
    check("rst cmdvalid", bus.spi_cmdvalid_o, 1'b0);
    check("rst cmdidx", bus.spi_cmdidx_o, 6'd0);
    check("rst cmdarg", bus.spi_cmdarg_o, 32'h0);
    check("rst cardidle", bus.spi_cardidle_o, 1'b1);
    check("rst busy", bus.spi_busy_o, 1'b0);
    spi_rst_i = 1'b0;
    repeat (4) @(negedge spi_clk_i);

    // 80 clocks of 0xFF with the card deselected
    for (int i = 0; i < 80; i++) begin
      #HALF bus.SCK_SPI = 1'b1;
      #HALF bus.SCK_SPI = 1'b0;
    end
    check("preamble cmdvalid", vcount, 0);
    bus.spi_cs_n_i = 1'b0;
    repeat (2) #HALF;

    do_cmd("cmd0", 48'h400000000095, 1'b1, 40'h01);
    do_cmd("cmd8", 48'h48000001AA87, 1'b1, 40'h01000001AA);
    check("cmd8 arg_lit", bus.spi_cmdarg_o, 32'h000001AA);
    do_cmd("cmd58_idle", 48'h7A0000000001, 1'b1, 40'h0140FF8000);
    for (int n = 0; n < 3; n++) begin
      do_cmd($sformatf("cmd55_%0d", n), 48'h770000000001, 1'b1, 40'h01);
      do_cmd($sformatf("acmd41_%0d", n), 48'h694000000077, 1'b1, (n == 2) ? 40'h00 : 40'h01);
    end
    check("init cardidle_lit", bus.spi_cardidle_o, 1'b0);
    do_cmd("cmd58_ready", 48'h7A0000000001, 1'b1, 40'h00C0FF8000);
    abort_after(48'h400000000095, 20);
    do_cmd("cmd17_ready", 48'h510000000001, 1'b1, 40'h04);
`ifdef SD_RESP_CRC_CHECK_EN
    do_cmd("cmd0_badcrc", 48'h400000000001, 1'b1, 40'h08);
`else
    do_cmd("cmd0_badcrc", 48'h400000000001, 1'b1, 40'h01);
`endif
    do_cmd("cmd41_noapp", 48'h694000000077, 1'b1, 40'h05);
    do_cmd("bad_end", 48'h400000000094, 1'b1, 40'hFF);
    do_cmd("bad_tx", 48'h000000000095, 1'b1, 40'hFF);

    for (int n = 0; n < 16; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       idx = 6'd0;
        1:       idx = 6'd8;
        2, 3:    idx = 6'd55;
        4, 5:    idx = 6'd41;
        6:       idx = 6'd58;
        7:       idx = 6'd17;
        default: idx = 6'($urandom);
      endcase
      arg = $urandom;
      f = mk(idx, arg);
      if ($urandom_range(0, 7) == 0)      f[0]  = 1'b0;
      else if ($urandom_range(0, 7) == 0) f[46] = 1'b0;
      do_cmd($sformatf("rnd%0d", n), f, 1'b0, 40'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
